// File: rtl/cfg_arb_pkg.sv
// Shared definitions for the configuration-bus arbiter: FSM state encoding
// and default bus geometry / timeout.
package cfg_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ADDR_W_DEF  = 3;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/cfg_rr_pick.sv
// Two-way round-robin selector: a lone requester wins outright, a tie goes
// to the requester named by ptr.
module cfg_rr_pick (
  input  logic v0,
  input  logic v1,
  input  logic ptr,
  output logic sel,
  output logic any
);

  assign any = v0 | v1;
  assign sel = (v0 & v1) ? ptr : v1;

endmodule

// File: rtl/cfg_bus_arbiter.sv
// Arbitrates two config-write requesters onto a single registered config bus
// with ready/valid handshake and a bounded wait before a write is dropped.
module cfg_bus_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_data,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_data,
  output logic              s1_ready,
  output logic [ADDR_W-1:0] c_addr,
  output logic [DATA_W-1:0] c_data,
  output logic              c_valid,
  input  logic              c_ready,
  output logic              busy,
  output logic              grant_src,
  output logic              timeout_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ptr_q, ptr_d;
  logic              c_valid_d, grant_d, terr_d;
  logic [ADDR_W-1:0] c_addr_d;
  logic [DATA_W-1:0] c_data_d;
  logic              pick_sel, pick_any;

  cfg_rr_pick u_pick (
    .v0  (s0_valid),
    .v1  (s1_valid),
    .ptr (ptr_q),
    .sel (pick_sel),
    .any (pick_any)
  );

  assign busy = (state_q == BUSY);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    c_valid_d = c_valid;
    c_addr_d  = c_addr;
    c_data_d  = c_data;
    grant_d   = grant_src;
    terr_d    = 1'b0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready implies the selected requester is valid, so asserting ready
        // is itself the accept.
        if (pick_any && !rst) begin
          s0_ready  = ~pick_sel;
          s1_ready  = pick_sel;
          c_addr_d  = pick_sel ? s1_addr : s0_addr;
          c_data_d  = pick_sel ? s1_data : s0_data;
          c_valid_d = 1'b1;
          grant_d   = pick_sel;
          ptr_d     = ~pick_sel;
          cnt_d     = 8'd0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (c_ready) begin
          c_valid_d = 1'b0;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          c_valid_d = 1'b0;
          terr_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      ptr_q       <= 1'b0;
      c_valid     <= 1'b0;
      c_addr      <= '0;
      c_data      <= '0;
      grant_src   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      c_valid     <= c_valid_d;
      c_addr      <= c_addr_d;
      c_data      <= c_data_d;
      grant_src   <= grant_d;
      timeout_err <= terr_d;
    end
  end

endmodule

// File: tb/tb_cfg_bus_arbiter.sv
// Scoreboard bench for cfg_bus_arbiter: accepted writes are queued when driven
// and matched against each config-bus handshake.
module tb_cfg_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic [2:0] s0_addr = '0, s1_addr = '0;
  logic [7:0] s0_data = '0, s1_data = '0;
  logic       s0_ready, s1_ready;
  logic [2:0] c_addr;
  logic [7:0] c_data;
  logic       c_valid;
  logic       c_ready = 1'b0;
  logic       busy, grant_src, timeout_err;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic       src;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_errors = 0;

  cfg_bus_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .s0_valid    (s0_valid),
    .s0_addr     (s0_addr),
    .s0_data     (s0_data),
    .s0_ready    (s0_ready),
    .s1_valid    (s1_valid),
    .s1_addr     (s1_addr),
    .s1_data     (s1_data),
    .s1_ready    (s1_ready),
    .c_addr      (c_addr),
    .c_data      (c_data),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .busy        (busy),
    .grant_src   (grant_src),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] a, input logic [7:0] d, input logic s);
    exp_t r;
    r.addr = a;
    r.data = d;
    r.src  = s;
    return r;
  endfunction

  // Handshake monitor: sampled mid-low-phase, after the driver has settled.
  always begin
    @(negedge clk);
    #2;
    if (!rst && c_valid && c_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_write", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_addr", 32'(c_addr), 32'(e.addr));
        chk("sb_data", 32'(c_data), 32'(e.data));
        chk("sb_src",  32'(grant_src), 32'(e.src));
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    c_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_c_valid", 32'(c_valid), 32'(0));
    chk("rst_c_addr",  32'(c_addr), 32'(0));
    chk("rst_c_data",  32'(c_data), 32'(0));
    chk("rst_grant",   32'(grant_src), 32'(0));
    chk("rst_busy",    32'(busy), 32'(0));
    chk("rst_terr",    32'(timeout_err), 32'(0));
  endtask

  initial begin
    // Ready must stay low while reset is asserted, even with requests pending.
    repeat (2) @(negedge clk);
    s0_valid = 1'b1;
    s1_valid = 1'b1;
    #1;
    chk("rst_s0_ready", 32'(s0_ready), 32'(0));
    chk("rst_s1_ready", 32'(s1_ready), 32'(0));
    do_reset();

    // Single write from s0.
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 3'd0; s0_data = 8'h0A; c_ready = 1'b1;
    sb_q.push_back(mk(3'd0, 8'h0A, 1'b0));
    #1;
    chk("single_s0_ready", 32'(s0_ready), 32'(1));
    chk("single_s1_ready", 32'(s1_ready), 32'(0));
    @(negedge clk);
    s0_valid = 1'b0;
    chk("single_c_valid", 32'(c_valid), 32'(1));
    chk("single_c_addr",  32'(c_addr), 32'(0));
    chk("single_c_data",  32'(c_data), 32'(8'h0A));
    chk("single_grant",   32'(grant_src), 32'(0));
    chk("single_busy",    32'(busy), 32'(1));
    @(negedge clk);
    chk("single_idle_vld",  32'(c_valid), 32'(0));
    chk("single_idle_busy", 32'(busy), 32'(0));

    // Contention: round-robin s0, s1, s0, s1 with a grant every 2 cycles.
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 3'd1; s0_data = 8'h5A;
    s1_valid = 1'b1; s1_addr = 3'd2; s1_data = 8'h5F;
    c_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      sb_q.push_back((i % 2 == 0) ? mk(3'd1, 8'h5A, 1'b0) : mk(3'd2, 8'h5F, 1'b1));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("cont_c_valid", 32'(c_valid), 32'(k % 2));
      if (k == 7) begin
        s0_valid = 1'b0;
        s1_valid = 1'b0;
      end
    end
    chk("cont_sb_drained", 32'(sb_q.size()), 32'(0));

    // Backpressure: target stalls 5 cycles; s1 must wait its turn.
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 3'd3; s0_data = 8'h33;
    s1_valid = 1'b1; s1_addr = 3'd4; s1_data = 8'h44;
    c_ready = 1'b0;
    sb_q.push_back(mk(3'd3, 8'h33, 1'b0));
    sb_q.push_back(mk(3'd4, 8'h44, 1'b1));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) s0_valid = 1'b0;
      if (k == 6) c_ready = 1'b1;
      if (k == 8) s1_valid = 1'b0;
      #1;
      chk("bp_terr", 32'(timeout_err), 32'(0));
      if (k <= 6) begin
        chk("bp_c_valid",  32'(c_valid), 32'(1));
        chk("bp_c_addr",   32'(c_addr), 32'(3));
        chk("bp_c_data",   32'(c_data), 32'(8'h33));
        chk("bp_s1_ready", 32'(s1_ready), 32'(0));
      end
      if (k == 7) chk("bp_s1_ready_idle", 32'(s1_ready), 32'(1));
      if (k == 8) chk("bp_s1_c_data", 32'(c_data), 32'(8'h44));
    end

    // Timeout: target never answers, write is dropped after 16 cycles.
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 3'd5; s0_data = 8'h77; c_ready = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) s0_valid = 1'b0;
      chk("to_c_valid", 32'(c_valid), 32'(k <= 16));
      chk("to_terr",    32'(timeout_err), 32'(k == 17));
    end
    s0_valid = 1'b1; s0_addr = 3'd6; s0_data = 8'h66; c_ready = 1'b1;
    sb_q.push_back(mk(3'd6, 8'h66, 1'b0));
    #1;
    chk("to_next_ready", 32'(s0_ready), 32'(1));
    @(negedge clk);
    s0_valid = 1'b0;
    chk("to_next_c_valid", 32'(c_valid), 32'(1));
    chk("to_next_c_data",  32'(c_data), 32'(8'h66));

    // Boundary: ready arrives on the last permitted waiting cycle.
    do_reset();
    @(negedge clk);
    s1_valid = 1'b1; s1_addr = 3'd7; s1_data = 8'h99; c_ready = 1'b0;
    sb_q.push_back(mk(3'd7, 8'h99, 1'b1));
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) s1_valid = 1'b0;
      if (k == 16) c_ready = 1'b1;
      chk("bnd_c_valid", 32'(c_valid), 32'(k <= 16));
      chk("bnd_terr",    32'(timeout_err), 32'(0));
    end

    // Reset while a write is pending: dropped silently, ptr back to 0.
    do_reset();
    @(negedge clk);
    s0_valid = 1'b1; s0_addr = 3'd2; s0_data = 8'h50; c_ready = 1'b0;
    @(negedge clk);
    s0_valid = 1'b0;
    chk("rb_c_valid_pre", 32'(c_valid), 32'(1));
    chk("rb_c_data_pre",  32'(c_data), 32'(8'h50));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rb_c_valid", 32'(c_valid), 32'(0));
    chk("rb_c_addr",  32'(c_addr), 32'(0));
    chk("rb_c_data",  32'(c_data), 32'(0));
    chk("rb_grant",   32'(grant_src), 32'(0));
    chk("rb_busy",    32'(busy), 32'(0));
    chk("rb_terr",    32'(timeout_err), 32'(0));
    s0_valid = 1'b1; s0_addr = 3'd1; s0_data = 8'h11;
    s1_valid = 1'b1; s1_addr = 3'd2; s1_data = 8'h22;
    c_ready = 1'b1;
    sb_q.push_back(mk(3'd1, 8'h11, 1'b0));
    #1;
    chk("rb_ptr_s0_ready", 32'(s0_ready), 32'(1));
    chk("rb_ptr_s1_ready", 32'(s1_ready), 32'(0));
    @(negedge clk);
    s0_valid = 1'b0;
    s1_valid = 1'b0;
    chk("rb_after_terr", 32'(timeout_err), 32'(0));
    repeat (3) @(negedge clk);
    chk("sb_final_empty", 32'(sb_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cfg_bus_arbiter.md
CFG_BUS_ARBITER -- requirements
Module: cfg_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, default 3, width of config address.
REQ-002 Parameter DATA_W, default 8, width of config data.
REQ-003 Parameter TIMEOUT, default 16, max cycles a write waits for c_ready before being dropped; legal range 2..255.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 s0_valid / s0_addr / s0_data  in  1/ADDR_W/DATA_W  requester 0 (UART config path) write request.
REQ-007 s0_ready  out  1  requester 0 write accepted this cycle.
REQ-008 s1_valid / s1_addr / s1_data  in  1/ADDR_W/DATA_W  requester 1 (default-colour loader) write request.
REQ-009 s1_ready  out  1  requester 1 write accepted this cycle.
REQ-010 c_addr / c_data  out  ADDR_W/DATA_W  config bus address/data, registered.
REQ-011 c_valid  out  1  config bus write pending, registered.
REQ-012 c_ready  in  1  config target accepts write when high with c_valid.
REQ-013 busy  out  1  high while state is BUSY.
REQ-014 grant_src  out  1  source of the current/last write (0 or 1).
REQ-015 timeout_err  out  1  one-cycle pulse when a write is dropped.

Function
REQ-016 States: IDLE, BUSY; reset to IDLE.
REQ-017 In IDLE, sN_ready = (sN is the selected requester); combinational; both ready low in BUSY.
REQ-018 Selection in IDLE: only one valid -> that one; both valid -> the one indicated by priority pointer ptr.
REQ-019 ptr resets to 0; after any accept from source N, ptr = not N (round-robin).
REQ-020 On accept (sN_valid && sN_ready) at edge E: c_addr/c_data latch sN data, c_valid=1, grant_src=N, state=BUSY, visible cycle after E (1-cycle latency).
REQ-021 c_addr/c_data/c_valid SHALL stay stable in BUSY until handshake or timeout.
REQ-022 BUSY, c_ready=1 -> c_valid=0, state=IDLE at next edge; new accept possible the following cycle (min 2 cycles per write).
REQ-023 Wait counter cnt (8 bit) clears on accept, increments each BUSY cycle with c_ready=0.
REQ-024 BUSY, c_ready=0 and cnt==TIMEOUT-1 -> c_valid=0, timeout_err=1 for one cycle, state=IDLE; write discarded, ptr unchanged.
REQ-025 c_ready=1 on the same cycle cnt==TIMEOUT-1 -> completes normally, no timeout_err.
REQ-026 c_ready while c_valid=0 SHALL be ignored.
REQ-027 Requester deasserting valid in IDLE before accept SHALL leave no state change.

Reset
REQ-028 rst=1 at an edge -> state IDLE, c_valid=0, c_addr=0, c_data=0, grant_src=0, busy=0, timeout_err=0, ptr=0, cnt=0, regardless of state.
REQ-029 Reset mid-BUSY SHALL drop the pending write without timeout_err.
REQ-030 sN_ready SHALL be low while rst=1.

Structure
REQ-031 Shared package cfg_arb_pkg holds state encoding (IDLE=0, BUSY=1) and default ADDR_W, DATA_W, TIMEOUT.
REQ-032 Round-robin select is one sub-module, cfg_rr_pick (inputs v0, v1, ptr; outputs sel, any).

Verification
REQ-033 Single: s0 addr=0, data=0x0A, c_ready=1 -> c_valid next cycle with c_addr=0, c_data=0x0A, grant_src=0; IDLE one cycle later.
REQ-034 Contention: s0 and s1 held valid (0x5A, 0x5F), c_ready=1 -> order s0, s1, s0, s1; each grant 2 cycles apart.
REQ-035 Backpressure: c_ready low 5 cycles then high -> c_addr/c_data stable 6 cycles, no timeout_err, s1 stalled with s1_ready=0.
REQ-036 Timeout: TIMEOUT=16, c_ready held 0 -> c_valid drops and timeout_err pulses exactly 16 cycles after c_valid rises; next write accepted.
REQ-037 Boundary: c_ready rises on 16th waiting cycle -> normal completion, timeout_err stays 0.
REQ-038 Reset in BUSY (c_valid=1, data 0x50) -> next cycle all outputs 0, ptr=0, no timeout_err.
